// File: rtl/pll_lock_sequencer.sv
// PLL bring-up controller: sequences pll_rst, qualifies a synchronized lock and
// gates clkout0, with bounded retries, lock-loss recovery and status reporting.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clkin1,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart_req,
    output logic       pll_rst,
    output logic       clkout0_gate,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CNT_NEED = $clog2(CNT_MAX + 1);
    localparam int CNT_W   = (CNT_NEED > 17) ? CNT_NEED : 17;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [3:0]       retry_q, retry_nxt;
    logic [7:0]       loss_q, loss_nxt;
    logic             lock_m, lock_s;
    logic             attempt_failed;

    // Two-flop synchronizer; pll_lock has no timing relation to clkin1.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    // Next-state logic. restart_req is a plain level sampled every cycle; it
    // takes priority over every lock, timeout and completion condition.
    always_comb begin
        state_nxt      = state_q;
        cnt_nxt        = cnt_q;
        retry_nxt      = retry_q;
        loss_nxt       = loss_q;
        attempt_failed = 1'b0;

        if (restart_req) begin
            state_nxt = ST_RESET;
            retry_nxt = 4'd0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_nxt = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = ST_STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        attempt_failed = 1'b1;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        attempt_failed = 1'b1;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_nxt = ST_RUN;
                        retry_nxt = 4'd0;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_nxt = ST_RESET;
                        if (loss_q != 8'hFF) begin
                            loss_nxt = loss_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt = ST_RESET;
                end
            endcase

            if (attempt_failed) begin
                if (retry_q < RETRY_LIMIT) begin
                    retry_nxt = retry_q + 4'd1;
                    state_nxt = ST_RESET;
                end else begin
                    state_nxt = ST_FAIL;
                end
            end
        end

        // The counter only runs in the timed states and restarts on any
        // transition, including a restart_req that re-enters RESET.
        if (restart_req || (state_nxt != state_q)) begin
            cnt_nxt = '0;
        end else if ((state_q == ST_RESET) || (state_q == ST_WAIT_LOCK) ||
                     (state_q == ST_STABLE)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end else begin
            cnt_nxt = '0;
        end
    end

    // Outputs are decoded from the next state so they move with state_q.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state_q      <= ST_RESET;
            cnt_q        <= '0;
            retry_q      <= 4'd0;
            loss_q       <= 8'd0;
            pll_rst      <= 1'b1;
            clkout0_gate <= 1'b0;
            ready        <= 1'b0;
            fail         <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            cnt_q        <= cnt_nxt;
            retry_q      <= retry_nxt;
            loss_q       <= loss_nxt;
            pll_rst      <= (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
            clkout0_gate <= (state_nxt == ST_RUN);
            ready        <= (state_nxt == ST_RUN);
            fail         <= (state_nxt == ST_FAIL);
        end
    end

    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small parameters so every
// timeout, retry and saturation path is reachable in a short run.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;
    localparam int MAX_RETRY    = 2;

    localparam logic [2:0] S_RESET = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_STAB  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_FAIL  = 3'd4;

    logic       clkin1;
    logic       rst;
    logic       pll_lock;
    logic       restart_req;
    logic       pll_rst;
    logic       clkout0_gate;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int total_checks;
    int bad_checks;
    logic [31:0] exp_q[$];

    pll_lock_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clkin1      (clkin1),
        .rst         (rst),
        .pll_lock    (pll_lock),
        .restart_req (restart_req),
        .pll_rst     (pll_rst),
        .clkout0_gate(clkout0_gate),
        .ready       (ready),
        .fail        (fail),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt),
        .state       (state)
    );

    // Clock and reset
    initial clkin1 = 1'b0;
    always #10 clkin1 = ~clkin1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clkin1);
    endtask

    // Counts edges until state reaches target; a blown budget shows up as a
    // failed state comparison.
    task automatic wait_state(input string tag, input logic [2:0] target,
                              input int max_cyc, output int cyc);
        cyc = 0;
        while ((state !== target) && (cyc < max_cyc)) begin
            @(negedge clkin1);
            cyc++;
        end
        check(tag, {29'd0, state}, {29'd0, target});
    endtask

    task automatic pulse_restart();
        restart_req = 1'b1;
        step(1);
        restart_req = 1'b0;
    endtask

    int cyc;

    initial begin
        total_checks = 0;
        bad_checks   = 0;
        rst          = 1'b1;
        pll_lock     = 1'b0;
        restart_req  = 1'b0;
        step(3);

        // Reset values
        check("rst_state", {29'd0, state}, {29'd0, S_RESET});
        check("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("rst_gate", {31'd0, clkout0_gate}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_fail", {31'd0, fail}, 32'd0);
        check("rst_retry", {28'd0, retry_cnt}, 32'd0);
        check("rst_loss", {24'd0, loss_cnt}, 32'd0);

        // Nominal bring-up
        rst = 1'b0;
        wait_state("nom_to_wait", S_WAIT, 20, cyc);
        check("nom_rst_len", cyc, RST_CYCLES);
        check("nom_pll_rst_low", {31'd0, pll_rst}, 32'd0);
        step(4);
        pll_lock = 1'b1;
        step(2);
        check("nom_sync_not_yet", {29'd0, state}, {29'd0, S_WAIT});
        step(1);
        check("nom_stable_entry", {29'd0, state}, {29'd0, S_STAB});
        step(7);
        check("nom_stable_hold", {29'd0, state}, {29'd0, S_STAB});
        check("nom_gate_closed", {31'd0, clkout0_gate}, 32'd0);
        step(1);
        check("nom_run", {29'd0, state}, {29'd0, S_RUN});
        check("nom_gate", {31'd0, clkout0_gate}, 32'd1);
        check("nom_ready", {31'd0, ready}, 32'd1);
        check("nom_retry", {28'd0, retry_cnt}, 32'd0);

        // Lock loss in RUN: 2 sync stages plus the state register
        pll_lock = 1'b0;
        step(2);
        check("loss_gate_still", {31'd0, clkout0_gate}, 32'd1);
        step(1);
        check("loss_gate", {31'd0, clkout0_gate}, 32'd0);
        check("loss_state", {29'd0, state}, {29'd0, S_RESET});
        check("loss_cnt1", {24'd0, loss_cnt}, 32'd1);
        check("loss_retry", {28'd0, retry_cnt}, 32'd0);
        check("loss_pll_rst", {31'd0, pll_rst}, 32'd1);

        // Timeout exhaustion with lock held low
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd2);
        for (int a = 0; a < MAX_RETRY; a++) begin
            wait_state("to_wait", S_WAIT, 20, cyc);
            check("to_rst_len", cyc, RST_CYCLES);
            wait_state("to_reset", S_RESET, 40, cyc);
            check("to_wait_len", cyc, LOCK_TIMEOUT);
            check("to_retry", {28'd0, retry_cnt}, exp_q.pop_front());
        end
        wait_state("to_wait_last", S_WAIT, 20, cyc);
        wait_state("to_fail", S_FAIL, 40, cyc);
        check("to_fail_len", cyc, LOCK_TIMEOUT);
        check("to_fail_flag", {31'd0, fail}, 32'd1);
        check("to_fail_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("to_fail_retry", {28'd0, retry_cnt}, MAX_RETRY);
        step(5);
        check("to_fail_sticky", {29'd0, state}, {29'd0, S_FAIL});

        // restart_req from FAIL
        pulse_restart();
        check("rs_fail_state", {29'd0, state}, {29'd0, S_RESET});
        check("rs_fail_retry", {28'd0, retry_cnt}, 32'd0);
        check("rs_fail_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("rs_fail_fail", {31'd0, fail}, 32'd0);
        check("rs_fail_loss_kept", {24'd0, loss_cnt}, 32'd1);
        wait_state("rs_fail_wait", S_WAIT, 20, cyc);
        check("rs_fail_rst_len", cyc, RST_CYCLES);

        // restart_req mid-WAIT_LOCK with a nonzero retry count
        wait_state("rs_mid_timeout", S_RESET, 40, cyc);
        check("rs_mid_retry_pre", {28'd0, retry_cnt}, 32'd1);
        wait_state("rs_mid_wait", S_WAIT, 20, cyc);
        step(5);
        pulse_restart();
        check("rs_mid_state", {29'd0, state}, {29'd0, S_RESET});
        check("rs_mid_retry", {28'd0, retry_cnt}, 32'd0);
        check("rs_mid_pll_rst", {31'd0, pll_rst}, 32'd1);
        wait_state("rs_mid_wait2", S_WAIT, 20, cyc);
        check("rs_mid_rst_len", cyc, RST_CYCLES);

        // One-cycle lock glitch three cycles into STABLE
        pll_lock = 1'b1;
        wait_state("gl_stable", S_STAB, 10, cyc);
        check("gl_sync_lat", cyc, 3);
        step(2);
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        wait_state("gl_reset", S_RESET, 10, cyc);
        check("gl_retry", {28'd0, retry_cnt}, 32'd1);
        wait_state("gl_wait", S_WAIT, 20, cyc);
        check("gl_rst_len", cyc, RST_CYCLES);
        wait_state("gl_stable2", S_STAB, 10, cyc);
        wait_state("gl_run", S_RUN, 20, cyc);
        check("gl_stable_len", cyc, LOCK_STABLE);
        check("gl_run_retry", {28'd0, retry_cnt}, 32'd0);
        check("gl_run_ready", {31'd0, ready}, 32'd1);

        // rst together with restart_req in RUN: rst wins, loss_cnt clears
        rst = 1'b1;
        restart_req = 1'b1;
        step(1);
        check("rr_state", {29'd0, state}, {29'd0, S_RESET});
        check("rr_pll_rst", {31'd0, pll_rst}, 32'd1);
        check("rr_gate", {31'd0, clkout0_gate}, 32'd0);
        check("rr_ready", {31'd0, ready}, 32'd0);
        check("rr_loss", {24'd0, loss_cnt}, 32'd0);
        rst = 1'b0;
        restart_req = 1'b0;

        // loss_cnt saturation over 256 lock losses
        for (int i = 0; i < 256; i++) begin
            wait_state("sat_run", S_RUN, 40, cyc);
            pll_lock = 1'b0;
            wait_state("sat_reset", S_RESET, 10, cyc);
            pll_lock = 1'b1;
            if (i == 254) check("sat_255", {24'd0, loss_cnt}, 32'd255);
        end
        check("sat_hold", {24'd0, loss_cnt}, 32'd255);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got=1 expected=0");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controller that sequences the PLL primitive wrapper's reset, lock qualification and clkout0 gating.
- Runs on the free-running 50 MHz reference clock, the same clock that drives the PLL's clkin1.
- Drives pll_rst and clkout0_gate and consumes pll_lock.
- Retries bounded lock failures, recovers from lock loss, and reports status to system control.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per reset attempt (min 1).
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before the attempt is declared failed (1 ms at 50 MHz).
- LOCK_STABLE, 1024: consecutive cycles of synchronized lock required before the clock is released.
- MAX_RETRY, 3: failed attempts tolerated before entering FAIL (1..15).

Ports:
- clkin1  in  1  reference clock, 50 MHz, free-running; all logic in this domain.
- rst  in  1  synchronous, active-high reset.
- pll_lock  in  1  PLL lock, asynchronous to clkin1; 2-FF synchronized internally to lock_s.
- restart_req  in  1  single-cycle request to restart the full sequence.
- pll_rst  out  1  PLL reset, active-high, registered.
- clkout0_gate  out  1  clkout0 enable, 1 = clock running, registered.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  4  failed attempts since last rst/restart_req/RUN entry.
- loss_cnt  out  8  lock-loss events while in RUN, saturates at 255.
- state  out  3  encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

Behaviour:
- Reset values while rst=1: state=RESET, pll_rst=1, clkout0_gate=0, ready=0, fail=0, retry_cnt=0, loss_cnt=0, sync flops=0, cycle counter=0.
- All outputs are registered decodes of the next state: an output changes in the same cycle as the state register.
- lock_s = pll_lock delayed 2 clkin1 cycles.
- Single cycle counter cnt (17 bits min, sized for max parameter). It clears on every state transition.
- RESET:
  - pll_rst=1, gate=0.
  - cnt counts up to RST_CYCLES-1, then go to WAIT_LOCK. pll_rst is therefore high exactly RST_CYCLES cycles per attempt.
- WAIT_LOCK:
  - pll_rst=0, gate=0.
  - If lock_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT-1, the attempt has failed.
- STABLE:
  - pll_rst=0, gate=0.
  - If lock_s=0, the attempt has failed (a glitch counts as a failure).
  - If lock_s=1 and cnt==LOCK_STABLE-1, go to RUN and clear retry_cnt.
- Attempt failure:
  - If retry_cnt < MAX_RETRY: increment retry_cnt and go to RESET.
  - Else go to FAIL; retry_cnt holds MAX_RETRY.
- RUN:
  - pll_rst=0, gate=1, ready=1.
  - If lock_s=0: go to RESET, increment loss_cnt (saturating), leave retry_cnt unchanged.
  - Gate falls the cycle after lock_s is first seen low.
- FAIL:
  - pll_rst=1 (PLL held in reset), gate=0, fail=1.
  - Exits only on restart_req or rst.
- restart_req, from any state including RESET:
  - Go to RESET and clear cnt and retry_cnt. loss_cnt is kept.
  - restart_req in RESET restarts the RST_CYCLES count.
- Priority in a single cycle: rst > restart_req > lock-loss/timeout/completion conditions.
- Simultaneous lock_s rise on the timeout cycle in WAIT_LOCK: lock wins, go to STABLE.
- Reset mid-operation: rst in any state forces the reset values on the next edge. The PLL re-enters reset and the gate closes immediately.
- No combinational path from any input to any output.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRY=2.
- Nominal bring-up:
  - Stimulus: release rst; raise pll_lock 5 cycles after pll_rst falls and hold it.
  - Required: pll_rst high 4 cycles; lock_s at +2; gate=1 and ready=1 exactly 8 cycles after STABLE entry; retry_cnt=0.
- Timeout exhaustion:
  - Stimulus: pll_lock held 0.
  - Required: three attempts, each 4 cycles reset + 20 cycles wait; retry_cnt goes 1, then 2; then FAIL with fail=1, pll_rst=1, state=4.
- Stability glitch:
  - Stimulus: lock rises, drops for 1 cycle 3 cycles into STABLE, then stays high.
  - Required: retry_cnt=1; new 4-cycle reset; then RUN; retry_cnt=0 on RUN entry.
- Lock loss in RUN:
  - Stimulus: drop pll_lock while in RUN.
  - Required: gate=0 three cycles after the pin falls (2 sync + 1); state=RESET; loss_cnt increments by 1; retry_cnt unchanged.
- restart_req from FAIL, and restart_req mid-WAIT_LOCK:
  - Required: next cycle state=RESET, retry_cnt=0, pll_rst=1 for a full 4 cycles.
- rst asserted in RUN, plus simultaneous restart_req:
  - Required: reset values on the next edge (rst wins).
- loss_cnt saturation:
  - Stimulus: 256 lock losses.
  - Required: loss_cnt holds 255.
